// File: rtl/sr_dmem_pkg.sv
// Shared definitions for the schoolRISCV data-memory controller.
//   - FSM state encoding used by sr_dmem_arbiter
//   - byte-enable constants for byte / half / word accesses
//   - bit positions inside the one-hot access-size vector {word, half, byte}
package sr_dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,  // only state that issues new SRAM accesses
        ST_CPU_WAIT = 2'd1,  // CPU load data returning from SRAM
        ST_EXT_WAIT = 2'd2   // external read data returning from SRAM
    } dmemState_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;  // shifted left by addr[1:0]
    localparam logic [3:0] BE_HALF = 4'b0011;  // shifted left by 2 when addr[1]
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int SZ_BYTE = 0;
    localparam int SZ_HALF = 1;
    localparam int SZ_WORD = 2;

endpackage

// File: rtl/sr_dmem_lane.sv
// Combinational byte-lane logic for CPU data accesses.
// Ports:
//   stAddr/stSize/stWdata  current CPU request: low address bits, one-hot
//                          size {word,half,byte}, raw store data
//   stBe/stData            SRAM byte enables and lane-replicated write data
//   misalign               current request is misaligned for its size
//   ldAddr/ldSize/ldSign   registered attributes of the outstanding load
//   rdata                  raw SRAM read word
//   ldData                 extracted and sign/zero-extended load result
module sr_dmem_lane
    import sr_dmem_pkg::*;
(
    input  logic [1:0]  stAddr,
    input  logic [2:0]  stSize,
    input  logic [31:0] stWdata,
    output logic [3:0]  stBe,
    output logic [31:0] stData,
    output logic        misalign,
    input  logic [1:0]  ldAddr,
    input  logic [2:0]  ldSize,
    input  logic        ldSign,
    input  logic [31:0] rdata,
    output logic [31:0] ldData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        stBe   = BE_WORD;
        stData = stWdata;
        if (stSize[SZ_BYTE]) begin
            stBe   = BE_BYTE << stAddr;
            stData = {4{stWdata[7:0]}};
        end else if (stSize[SZ_HALF]) begin
            stBe   = stAddr[1] ? (BE_HALF << 2) : BE_HALF;
            stData = {2{stWdata[15:0]}};
        end
    end

    assign misalign = (stSize[SZ_HALF] & stAddr[0]) |
                      (stSize[SZ_WORD] & (|stAddr));

    always_comb begin
        case (ldAddr)
            2'd0:    byteSel = rdata[7:0];
            2'd1:    byteSel = rdata[15:8];
            2'd2:    byteSel = rdata[23:16];
            default: byteSel = rdata[31:24];
        endcase
        halfSel = ldAddr[1] ? rdata[31:16] : rdata[15:0];

        ldData = rdata;
        if (ldSize[SZ_BYTE]) begin
            ldData = {{24{ldSign & byteSel[7]}}, byteSel};
        end else if (ldSize[SZ_HALF]) begin
            ldData = {{16{ldSign & halfSel[15]}}, halfSel};
        end
    end

endmodule

// File: rtl/sr_dmem_arbiter.sv
// Data-memory controller: shares one single-port synchronous SRAM (1-cycle
// read latency, byte-enable writes) between the CPU data port and an external
// word-wide master, with a starvation counter guaranteeing the external side
// a grant after STARVE_MAX consecutive contended CPU wins.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_*                         CPU request, formatted load data, stall,
//                                 misaligned-access pulse
//   ext_valid/ext_ready/ext_*     external request channel
//   ext_rvalid/ext_rdata          external read return (1-cycle pulse)
//   mem_*                         SRAM port
//
// External handshake: a request transfers in the cycle where ext_valid and
// ext_ready are both 1. The master holds ext_we/ext_addr/ext_wdata stable
// while ext_valid is high and ext_ready is low; ext_ready is only raised in a
// cycle where ext_valid is already high. Read data follows on ext_rvalid
// exactly one cycle after the transfer.
//
// All outputs are combinational from the registered state and the inputs,
// and are forced to 0 while rst is high.
module sr_dmem_arbiter
    import sr_dmem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_byte,
    input  logic              cpu_half,
    input  logic              cpu_word,
    input  logic              cpu_sign,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              misalign_err,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    dmemState_t    state, stateNext;
    logic [SW-1:0] starveCnt, starveNext;

    // Attributes of the outstanding CPU load, captured when it is issued.
    logic [1:0]    ldAddrQ;
    logic [2:0]    ldSizeQ;
    logic          ldSignQ;
    logic          captureLd;

    logic [2:0]    cpuSize;
    logic [3:0]    laneBe;
    logic [31:0]   laneData;
    logic          laneMisalign;
    logic [31:0]   laneLdData;
    logic          cpuWins;

    // Address bits outside the SRAM word range are intentionally ignored.
    logic          unusedBits;
    assign unusedBits = ^{cpu_addr[31:ADDR_W+2], ext_addr[31:ADDR_W+2], ext_addr[1:0]};

    assign cpuSize = {cpu_word, cpu_half, cpu_byte};

    sr_dmem_lane uLane (
        .stAddr   (cpu_addr[1:0]),
        .stSize   (cpuSize),
        .stWdata  (cpu_wdata),
        .stBe     (laneBe),
        .stData   (laneData),
        .misalign (laneMisalign),
        .ldAddr   (ldAddrQ),
        .ldSize   (ldSizeQ),
        .ldSign   (ldSignQ),
        .rdata    (mem_rdata),
        .ldData   (laneLdData)
    );

    // The CPU yields only when the external side has been starved long enough.
    assign cpuWins = cpu_req && !(ext_valid && (starveCnt == STARVE_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            starveCnt <= '0;
            ldAddrQ   <= '0;
            ldSizeQ   <= '0;
            ldSignQ   <= 1'b0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveNext;
            if (captureLd) begin
                ldAddrQ <= cpu_addr[1:0];
                ldSizeQ <= cpuSize;
                ldSignQ <= cpu_sign;
            end
        end
    end

    always_comb begin
        stateNext    = state;
        starveNext   = starveCnt;
        captureLd    = 1'b0;
        cpu_rdata    = '0;
        cpu_stall    = 1'b0;
        misalign_err = 1'b0;
        ext_ready    = 1'b0;
        ext_rvalid   = 1'b0;
        ext_rdata    = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (cpuWins) begin
                        // A misaligned attempt still counts against the ext side.
                        if (ext_valid && (starveCnt != STARVE_LIM)) begin
                            starveNext = starveCnt + SW'(1);
                        end
                        if (laneMisalign) begin
                            misalign_err = 1'b1;
                        end else if (cpu_we) begin
                            mem_en    = 1'b1;
                            mem_we    = 1'b1;
                            mem_be    = laneBe;
                            mem_addr  = cpu_addr[ADDR_W+1:2];
                            mem_wdata = laneData;
                        end else begin
                            mem_en    = 1'b1;
                            mem_be    = laneBe;
                            mem_addr  = cpu_addr[ADDR_W+1:2];
                            cpu_stall = 1'b1;
                            captureLd = 1'b1;
                            stateNext = ST_CPU_WAIT;
                        end
                    end else if (ext_valid) begin
                        ext_ready  = 1'b1;
                        mem_en     = 1'b1;
                        mem_we     = ext_we;
                        mem_be     = BE_WORD;
                        mem_addr   = ext_addr[ADDR_W+1:2];
                        mem_wdata  = ext_wdata;
                        cpu_stall  = cpu_req;
                        starveNext = '0;
                        if (!ext_we) begin
                            stateNext = ST_EXT_WAIT;
                        end
                    end
                end
                ST_CPU_WAIT: begin
                    cpu_rdata = laneLdData;
                    stateNext = ST_IDLE;
                end
                ST_EXT_WAIT: begin
                    ext_rvalid = 1'b1;
                    ext_rdata  = mem_rdata;
                    cpu_stall  = cpu_req;
                    stateNext  = ST_IDLE;
                end
                default: begin
                    stateNext = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_dmem_arbiter.sv
// Directed bench for sr_dmem_arbiter with a behavioural 1-cycle-latency SRAM.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_sr_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_byte, cpu_half, cpu_word, cpu_sign;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, misalign_err;
    logic        ext_valid, ext_ready, ext_we, ext_rvalid;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] sram [0:1023];

    always #5 clk = ~clk;

    sr_dmem_arbiter #(.ADDR_W(10), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_byte     (cpu_byte),
        .cpu_half     (cpu_half),
        .cpu_word     (cpu_word),
        .cpu_sign     (cpu_sign),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .misalign_err (misalign_err),
        .ext_valid    (ext_valid),
        .ext_ready    (ext_ready),
        .ext_we       (ext_we),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_rvalid   (ext_rvalid),
        .ext_rdata    (ext_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Single-port synchronous SRAM model with byte enables.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Move to the next falling edge (input-drive point).
    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic cpuIdle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_byte = 1'b0; cpu_half = 1'b0; cpu_word = 1'b0; cpu_sign = 1'b0;
    endtask

    // size: 0 = byte, 1 = half, 2 = word
    task automatic cpuOp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int size, input logic sign);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cpu_byte = (size == 0); cpu_half = (size == 1); cpu_word = (size == 2);
        cpu_sign = sign;
    endtask

    task automatic extOp(input logic valid, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        ext_valid = valid; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = '0;
        mem_rdata = '0;
        rst = 1'b1;
        cpuIdle();
        extOp(1'b0, 1'b0, '0, '0);

        // Reset: outputs forced low even with requests pending.
        nextCycle();
        cpuOp(1'b0, 32'h4, '0, 2, 1'b0);
        extOp(1'b1, 1'b0, 32'h40, '0);
        #1;
        checkVal("rst_ctrl", {26'd0, cpu_stall, mem_en, ext_ready, misalign_err, ext_rvalid, mem_we}, 32'h0);
        checkVal("rst_cpu_rdata", cpu_rdata, 32'h0);
        nextCycle();
        #1;
        checkVal("rst_starve_cnt", 32'(dut.starveCnt), 32'h0);

        // Store byte 0xA5 at 0x6.
        nextCycle();
        rst = 1'b0;
        extOp(1'b0, 1'b0, '0, '0);
        cpuOp(1'b1, 32'h6, 32'h0000_00A5, 0, 1'b0);
        #1;
        checkVal("sb_be", 32'(mem_be), 32'h4);
        checkVal("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        checkVal("sb_ctrl", {29'd0, mem_en, mem_we, cpu_stall}, 32'h6);
        checkVal("sb_addr", 32'(mem_addr), 32'h1);

        // Signed byte load from 0x6.
        nextCycle();
        cpuOp(1'b0, 32'h6, '0, 0, 1'b1);
        #1;
        checkVal("lb_issue_ctrl", {29'd0, mem_en, mem_we, cpu_stall}, 32'h5);
        nextCycle();
        #1;
        checkVal("lb_wait_stall", 32'(cpu_stall), 32'h0);
        checkVal("lb_data", cpu_rdata, 32'hFFFF_FFA5);

        // Unsigned byte load from 0x6.
        nextCycle();
        cpuOp(1'b0, 32'h6, '0, 0, 1'b0);
        #1;
        checkVal("lbu_issue_stall", 32'(cpu_stall), 32'h1);
        nextCycle();
        #1;
        checkVal("lbu_data", cpu_rdata, 32'h0000_00A5);

        // External write of 0x80011234 at 0x0, CPU idle.
        nextCycle();
        cpuIdle();
        extOp(1'b1, 1'b1, 32'h0, 32'h8001_1234);
        #1;
        checkVal("extw_ctrl", {28'd0, ext_ready, mem_en, mem_we, cpu_stall}, 32'hE);
        checkVal("extw_be", 32'(mem_be), 32'hF);

        // Signed half load at 0x2.
        nextCycle();
        extOp(1'b0, 1'b0, '0, '0);
        cpuOp(1'b0, 32'h2, '0, 1, 1'b1);
        #1;
        checkVal("lh_issue_stall", 32'(cpu_stall), 32'h1);
        nextCycle();
        #1;
        checkVal("lh_data", cpu_rdata, 32'hFFFF_8001);

        // Misaligned word load at 0x5.
        nextCycle();
        cpuOp(1'b0, 32'h5, '0, 2, 1'b0);
        #1;
        checkVal("mis_ctrl", {29'd0, misalign_err, mem_en, cpu_stall}, 32'h4);
        checkVal("mis_rdata", cpu_rdata, 32'h0);
        nextCycle();
        cpuIdle();
        #1;
        checkVal("mis_pulse_end", 32'(misalign_err), 32'h0);

        // Ext write 0xDEADBEEF at 0x40, then ext read back.
        extOp(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        nextCycle();
        extOp(1'b1, 1'b0, 32'h40, '0);
        #1;
        checkVal("extr_ready", {30'd0, ext_ready, mem_we}, 32'h2);
        checkVal("extr_addr", 32'(mem_addr), 32'h10);
        nextCycle();
        extOp(1'b0, 1'b0, '0, '0);
        cpuOp(1'b1, 32'h100, 32'h1111_2222, 2, 1'b0);
        #1;
        checkVal("extr_rvalid", {29'd0, ext_rvalid, ext_ready, mem_en}, 32'h4);
        checkVal("extr_rdata", ext_rdata, 32'hDEAD_BEEF);
        checkVal("extr_cpu_stall", 32'(cpu_stall), 32'h1);
        nextCycle();
        #1;
        checkVal("post_ext_store", {29'd0, mem_en, mem_we, cpu_stall}, 32'h6);

        // Starvation: continuous CPU stores against a pending ext write.
        nextCycle();
        cpuOp(1'b1, 32'h300, 32'h5555_AAAA, 2, 1'b0);
        extOp(1'b1, 1'b1, 32'h200, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkVal($sformatf("starve_cpu_win%0d", i), {28'd0, ext_ready, mem_en, mem_we, cpu_stall}, 32'h6);
            checkVal($sformatf("starve_cnt%0d", i), 32'(dut.starveCnt), 32'(i));
            nextCycle();
        end
        #1;
        checkVal("starve_ext_grant", {30'd0, ext_ready, cpu_stall}, 32'h3);
        checkVal("starve_ext_addr", 32'(mem_addr), 32'h80);
        nextCycle();
        extOp(1'b0, 1'b0, '0, '0);
        #1;
        checkVal("starve_cnt_clear", 32'(dut.starveCnt), 32'h0);

        // Reset in the cycle after an ext read grant.
        nextCycle();
        cpuIdle();
        extOp(1'b1, 1'b0, 32'h40, '0);
        #1;
        checkVal("rr_grant", 32'(ext_ready), 32'h1);
        nextCycle();
        extOp(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        checkVal("rr_outputs", {27'd0, ext_rvalid, ext_ready, cpu_stall, mem_en, mem_we}, 32'h0);
        checkVal("rr_ext_rdata", ext_rdata, 32'h0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkVal("rr_no_rvalid", 32'(ext_rvalid), 32'h0);

        // CPU word load at 0x40 after reset.
        nextCycle();
        cpuOp(1'b0, 32'h40, '0, 2, 1'b0);
        #1;
        checkVal("rr_lw_stall", {30'd0, mem_en, cpu_stall}, 32'h3);
        nextCycle();
        cpuIdle();
        #1;
        checkVal("rr_lw_data", cpu_rdata, 32'hDEAD_BEEF);

        nextCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
